caravel_ram_banked: RTL
=======================

# caravel_ram_banked

Parametrised banked SRAM block for the Caravel management/user memory space, and the successor to the fixed 24 KB single-macro RAM wrapper. It presents one synchronous single-port word interface with byte-lane writes over a configurable number of equal banks. It adds a request/ready handshake, a one-cycle read-valid strobe, and an optional hardware clear-after-reset sequencer. Bank storage is behavioural, one array per bank, so it can later be swapped for hard macros.

## Interface
- BANKS, default 4: number of banks; power of two, ≥2.
- BANK_AW, default 11: address bits per bank (2^BANK_AW words per bank).
- DW, default 32: data width; a multiple of 8.
- CLEAR_ON_RESET, default 1: when set, all words are zeroed by a sequencer after reset.
- Derived: NB = DW/8 byte lanes; AW = BANK_AW + log2(BANKS).
- CLK  in  1  sole clock; all logic updates on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- EN  in  1  request valid.
- WE  in  NB  byte-lane write enables; all-zero means read.
- A  in  AW  word address; upper log2(BANKS) bits select the bank, lower BANK_AW bits select the word.
- Di  in  DW  write data; lane i is Di[8i+7:8i].
- Do  out  DW  read data; registered.
- VLD  out  1  read data valid; one-cycle pulse.
- RDY  out  1  block accepts a request this cycle.
- BUSY  out  1  clear sequence in progress.

## Operation
- States: CLEAR, RUN.
- Reset, sampled at a CLK edge with RST=1:
  - state becomes CLEAR if CLEAR_ON_RESET=1, else RUN;
  - clear counter = 0, Do = 0, VLD = 0.
- CLEAR state:
  - each cycle, writes zero to word[counter] in every bank in parallel and increments the counter;
  - after writing word 2^BANK_AW−1, moves to RUN;
  - RDY=0 and BUSY=1 throughout; EN is ignored.
- RUN state: RDY=1 and BUSY=0. A request is accepted when EN=1 and RDY=1.
- Accepted write (WE≠0):
  - in the selected bank/word, each lane with WE[i]=1 takes Di lane i; other lanes are unchanged;
  - no VLD pulse; Do is unchanged.
- Accepted read (WE=0):
  - the selected word is registered into Do at the same edge;
  - VLD=1 for the following cycle.
- VLD is 0 in any cycle that does not follow an accepted read.
- Do holds its last value until the next accepted read.
- Only the selected bank is enabled per access; unselected banks see no write and no read.
- All addresses in 0..2^AW−1 are valid; there is no out-of-range case and no wrap logic.
- Single port: one access per cycle; there is no simultaneous read/write case.
- RST asserted mid-CLEAR: the counter restarts at 0 and the full sweep repeats.
- RST asserted in RUN: any pending VLD is dropped; memory contents are untouched unless a clear follows.

## Timing
- Read latency: 1 cycle. Request at edge N; Do and VLD are valid in the cycle after edge N; VLD drops at edge N+1 unless another read is accepted.
- Back-to-back reads: one per cycle, with VLD held high continuously.
- Write then read of the same address on consecutive cycles returns the newly written data; no forwarding is needed because the write commits at its edge.
- Clear duration: exactly 2^BANK_AW cycles after the first edge with RST=0. RDY rises in the following cycle. With defaults, 2048 cycles.
- With CLEAR_ON_RESET=0: RDY=1 in the first cycle after the reset edge.
- Output values during and immediately after reset:

| CLEAR_ON_RESET | Do | VLD | RDY | BUSY |
|---|---|---|---|---|
| 1 | 0 | 0 | 0 | 1 |
| 0 | 0 | 0 | 1 | 0 |

## Test plan
- **Clear after reset.** Preload garbage, apply RST for 2 cycles, then release. Required: BUSY=1 and RDY=0 for 2048 cycles, RDY=1 on the next cycle, and reads of addresses 0x0000, 0x07FF, 0x0800 and 0x1FFF return 0.
- **Full write and read-back.** Write 0xDEADBEEF to address 0x1A3 with WE=4'hF, then read it. Required: Do=0xDEADBEEF with VLD=1 exactly one cycle after the read request.
- **Byte lanes.** Write 0x11223344 with WE=4'hF, then 0xAABBCCDD with WE=4'b0101 to the same address, then read. Required: Do=0x11BB33DD.
- **Bank isolation.** Write 0xA0+b to word 5 of each bank b (addresses b·0x800+5), then read all four. Required: 0xA0, 0xA1, 0xA2, 0xA3, each on its own VLD pulse, with back-to-back reads keeping VLD high for 4 consecutive cycles.
- **Gating during clear and reset mid-clear.**
  - Assert EN with writes while BUSY=1. Required: no memory change and no VLD.
  - Assert RST at clear count 1000. Required: BUSY stays high for 2048 cycles after release.
- **No-clear configuration.** With CLEAR_ON_RESET=0, a read issued in the first cycle after reset is accepted. Required: RDY=1, and VLD=1 on the next cycle.

Source files
------------

// File: rtl/caravel_ram_banked_if.sv
// Request/response bundle for caravel_ram_banked: single-port word access with
// byte-lane writes, registered read data, read-valid strobe and ready/busy status.
interface caravel_ram_banked_if #(
    parameter int AW = 13,
    parameter int DW = 32
);
    localparam int NB = DW / 8;

    logic          EN;
    logic [NB-1:0] WE;
    logic [AW-1:0] A;
    logic [DW-1:0] Di;
    logic [DW-1:0] Do;
    logic          VLD;
    logic          RDY;
    logic          BUSY;

    modport master (output EN, WE, A, Di, input Do, VLD, RDY, BUSY);
    modport slave  (input EN, WE, A, Di, output Do, VLD, RDY, BUSY);
endinterface

// File: rtl/caravel_ram_banked.sv
// Banked single-port SRAM with byte-lane writes, 1-cycle registered reads and an
// optional zero-fill sweep of every bank after reset.
module caravel_ram_banked #(
    parameter int BANKS          = 4,
    parameter int BANK_AW        = 11,
    parameter int DW             = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic CLK,
    input logic RST,
    caravel_ram_banked_if.slave bus
);
    localparam int NB = DW / 8;
    localparam int BW = $clog2(BANKS);
    localparam int AW = BANK_AW + BW;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]         state_reg;
    logic [0:0]         state_next;
    logic [BANK_AW-1:0] clr_cnt_reg;
    logic [BW-1:0]      rd_bank_reg;
    logic               vld_reg;

    logic               running;
    logic               accept;
    logic               is_read;
    logic [BW-1:0]      sel_bank;
    logic [BANK_AW-1:0] word;
    logic [DW-1:0]      bank_rd [BANKS];

    assign running  = (state_reg == S_RUN);
    assign accept   = running && bus.EN;
    assign is_read  = accept && (bus.WE == '0);
    assign sel_bank = bus.A[AW-1:BANK_AW];
    assign word     = bus.A[BANK_AW-1:0];

    always_comb begin
        state_next = state_reg;
        if (state_reg == S_CLEAR && (&clr_cnt_reg)) begin
            state_next = S_RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_cnt_reg <= '0;
            vld_reg     <= 1'b0;
            rd_bank_reg <= '0;
        end else begin
            state_reg <= state_next;
            vld_reg   <= is_read;
            if (is_read) begin
                rd_bank_reg <= sel_bank;
            end
            if (!running) begin
                clr_cnt_reg <= clr_cnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [DW-1:0] mem [2**BANK_AW];
            logic [DW-1:0] rd_q_reg;
            logic          hit;

            assign hit = (sel_bank == BW'(gi));

            // The clear sweep hits every bank at once; normal accesses only the selected one.
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    if (!running) begin
                        mem[clr_cnt_reg] <= '0;
                    end else if (accept && hit) begin
                        for (int i = 0; i < NB; i++) begin
                            if (bus.WE[i]) begin
                                mem[word][8*i +: 8] <= bus.Di[8*i +: 8];
                            end
                        end
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_q_reg <= '0;
                end else if (is_read && hit) begin
                    rd_q_reg <= mem[word];
                end
            end

            assign bank_rd[gi] = rd_q_reg;
        end
    endgenerate

    // Each bank holds its last read word, so selecting by the last-read bank keeps Do stable.
    assign bus.Do   = bank_rd[rd_bank_reg];
    assign bus.VLD  = vld_reg;
    assign bus.RDY  = running;
    assign bus.BUSY = !running;
endmodule
